// File: rtl/bram_stream_reader.sv
// Streams len words read from a 1-cycle-latency BRAM onto a valid/ready port.
// Optional: define BRAM_STREAM_BITREV_EN to bit-reverse the issued read addresses.
module bram_stream_reader #(
  parameter int DLEN = 32,
  parameter int HLEN = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [HLEN-1:0] base,
  input  logic [HLEN:0]   len,
  output logic            busy,
  output logic            done,
  output logic [HLEN-1:0] ram_raddr,
  input  logic [DLEN-1:0] ram_dout,
  output logic [DLEN-1:0] m_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            m_last
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [HLEN-1:0] base_reg;
  logic [HLEN:0]   len_reg;
  logic [HLEN:0]   issue_cnt_reg;
  logic [HLEN:0]   beat_cnt_reg;
  logic [HLEN-1:0] raddr_reg;
  logic [DLEN-1:0] fifo_reg [2];
  logic            rd_ptr_reg, wr_ptr_reg;
  logic [1:0]      occ_reg;
  logic            inflight_reg;

  logic            pop, issue, last_beat;
  logic [2:0]      pending;
  logic [HLEN-1:0] logical_addr, phys_addr;

  assign m_valid   = (occ_reg != 2'd0);
  assign m_data    = fifo_reg[rd_ptr_reg];
  assign pop       = m_valid & m_ready;
  assign last_beat = (beat_cnt_reg == len_reg - (HLEN+1)'(1));
  assign m_last    = m_valid & last_beat;
  assign busy      = (state_reg == RUN) || (state_reg == DRAIN);
  assign done      = (state_reg == DONE);

  // Words the FIFO will hold after this edge; a new read fits only if this is below 2.
  assign pending = {1'b0, occ_reg} + {2'b00, inflight_reg} - {2'b00, pop};
  assign issue   = (state_reg == RUN) && (pending < 3'd2);

  assign logical_addr = base_reg + issue_cnt_reg[HLEN-1:0];

`ifdef BRAM_STREAM_BITREV_EN
  genvar gi;
  generate
    for (gi = 0; gi < HLEN; gi++) begin : g_bitrev
      assign phys_addr[gi] = logical_addr[HLEN-1-gi];
    end
  endgenerate
`else
  assign phys_addr = logical_addr;
`endif

  // The address bus shows the new read only in the cycle it is issued, else holds.
  assign ram_raddr = issue ? phys_addr : raddr_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start) state_next = (len == '0) ? DONE : RUN;
      RUN:   if (issue && (issue_cnt_reg + (HLEN+1)'(1) == len_reg)) state_next = DRAIN;
      DRAIN: if (pop && last_beat) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      base_reg      <= '0;
      len_reg       <= '0;
      issue_cnt_reg <= '0;
      beat_cnt_reg  <= '0;
      raddr_reg     <= '0;
      fifo_reg[0]   <= '0;
      fifo_reg[1]   <= '0;
      rd_ptr_reg    <= 1'b0;
      wr_ptr_reg    <= 1'b0;
      occ_reg       <= 2'd0;
      inflight_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && start) begin
        base_reg      <= base;
        len_reg       <= len;
        issue_cnt_reg <= '0;
        beat_cnt_reg  <= '0;
      end
      if (issue) begin
        issue_cnt_reg <= issue_cnt_reg + (HLEN+1)'(1);
        raddr_reg     <= phys_addr;
      end
      inflight_reg <= issue;
      if (inflight_reg) begin
        fifo_reg[wr_ptr_reg] <= ram_dout;
        wr_ptr_reg           <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg   <= ~rd_ptr_reg;
        beat_cnt_reg <= beat_cnt_reg + (HLEN+1)'(1);
      end
      occ_reg <= pending[1:0];
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a behavioural 512x32 BRAM (mem[k]=k+100).
module tb_bram_stream_reader;

  logic        clk = 1'b0;
  logic        reset, start, m_ready;
  logic [8:0]  base;
  logic [9:0]  len;
  logic        busy, done, m_valid, m_last;
  logic [8:0]  ram_raddr;
  logic [31:0] ram_dout, m_data;
  logic [31:0] mem [512];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) ram_dout <= mem[ram_raddr];

  bram_stream_reader #(.DLEN(32), .HLEN(9)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .len(len),
    .busy(busy), .done(done), .ram_raddr(ram_raddr), .ram_dout(ram_dout),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] exp_addr(input int a);
    logic [8:0] v, r;
    v = a[8:0];
    r = v;
`ifdef BRAM_STREAM_BITREV_EN
    for (int i = 0; i < 9; i++) r[i] = v[8-i];
`endif
    return r;
  endfunction

  // mode 0: m_ready held high (exact latency checked); mode 1: ready pattern 1,0,0 repeating.
  // poke: pulse start with other parameters while the burst is busy.
  task automatic run_burst(input int b, input int l, input int mode, input bit poke);
    int k;
    bit stalled, finished;
    logic [31:0] held_data;
    logic held_last;
    k = 0; stalled = 0; finished = 0; held_data = '0; held_last = 0;
    step();
    start = 1'b1; base = b[8:0]; len = l[9:0];
    m_ready = 1'b1;
    for (int c = 1; c < 3000 && !finished; c++) begin
      step();
      start = poke && (c == 2);
      if (poke) begin base = 9'd50; len = 10'd3; end
      m_ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
      #1;
      if (mode == 0 && c <= l) check("raddr", ram_raddr, exp_addr(b + c - 1));
      if (stalled) begin
        check("stall_valid", m_valid, 1'b1);
        check("stall_data", m_data, held_data);
        check("stall_last", m_last, held_last);
      end
      if (m_valid && m_ready) begin
        check("beat_data", m_data, 32'(exp_addr(b + k)) + 32'd100);
        check("beat_last", m_last, (k == l - 1));
        if (mode == 0) check("beat_cycle", c, k + 3);
        k++;
      end
      stalled = m_valid && !m_ready;
      held_data = m_data;
      held_last = m_last;
      if (done) begin
        check("beat_count", k, l);
        check("done_busy", busy, 1'b0);
        if (mode == 0) check("done_cycle", c, l + 3);
        finished = 1;
      end else begin
        check("busy", busy, 1'b1);
      end
    end
    if (!finished) check("done_timeout", 0, 1);
    start = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 512; k++) mem[k] = k + 100;
    reset = 1'b1; start = 1'b0; base = '0; len = '0; m_ready = 1'b0;
    step(); step();
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", m_valid, 1'b0);
    check("rst_last", m_last, 1'b0);
    check("rst_data", m_data, 32'd0);
    check("rst_raddr", ram_raddr, 9'd0);
    reset = 1'b0;

    // base=4 len=4 back-to-back: data 104..107 in cycles 3..6, done cycle 7
    run_burst(4, 4, 0, 0);
    // toggled ready with a start while busy that must be ignored
    run_burst(4, 4, 1, 1);
    // address wrap 510,511,0,1
    run_burst(510, 4, 0, 0);

    // len=0: no beats, done in cycle 1
    step();
    start = 1'b1; base = 9'd7; len = 10'd0;
    step();
    start = 1'b0;
    #1;
    check("len0_done", done, 1'b1);
    check("len0_busy", busy, 1'b0);
    check("len0_valid", m_valid, 1'b0);
    step();
    #1;
    check("len0_done_pulse", done, 1'b0);
    check("len0_valid2", m_valid, 1'b0);

    // full memory sweep
    run_burst(0, 512, 0, 0);

    // reset asserted in cycle 4 of a len=8 burst
    step();
    start = 1'b1; base = 9'd0; len = 10'd8; m_ready = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    reset = 1'b1;
    step();
    #1;
    check("abort_valid", m_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_last", m_last, 1'b0);
    check("abort_data", m_data, 32'd0);
    check("abort_raddr", ram_raddr, 9'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      check("abort_no_done", done, 1'b0);
      check("abort_no_valid", m_valid, 1'b0);
    end
    run_burst(0, 2, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
